fc_mover_nlane: RTL

- Parametrised multi-lane fully-connected data mover; successor to the two-lane FC mover.
- Reads node and weight vectors from two BRAMs and one bias word from a third.
- Runs NUM_LANE signed MAC lanes in parallel.
- Writes the lane results sequentially into an output BRAM; also exposes them flat.
- Sits between the AXI-lite control register file and the FC BRAM bank.

---
 rtl/fc_mover_nlane.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fc_mover_nlane.sv
// Multi-lane fully-connected data mover: loads a bias word, streams node/weight vectors
// through NUM_LANE signed MACs, then writes lane results to BRAM. Optional macro: FC_MOVER_RELU_EN.
module fc_mover_nlane #(
    parameter int CNT_BIT       = 16,
    parameter int AWIDTH        = 12,
    parameter int IN_DATA_WIDTH = 16,
    parameter int NUM_LANE      = 4,
    parameter int DWIDTH        = NUM_LANE * IN_DATA_WIDTH,
    parameter int ACC_WIDTH     = 48
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_run,
    input  logic [CNT_BIT-1:0]            i_num_cnt,
    input  logic [AWIDTH-1:0]             i_bias_addr,
    input  logic [AWIDTH-1:0]             i_out_base,
    output logic                          o_idle,
    output logic                          o_read,
    output logic                          o_write,
    output logic                          o_done,
    output logic [AWIDTH-1:0]             addr_b0,
    output logic                          ce_b0,
    input  logic [DWIDTH-1:0]             q_b0,
    output logic [AWIDTH-1:0]             addr_b1,
    output logic                          ce_b1,
    input  logic [DWIDTH-1:0]             q_b1,
    output logic [AWIDTH-1:0]             addr_b2,
    output logic                          ce_b2,
    input  logic [DWIDTH-1:0]             q_b2,
    output logic [AWIDTH-1:0]             addr_b3,
    output logic                          ce_b3,
    output logic                          we_b3,
    output logic [ACC_WIDTH-1:0]          d_b3,
    output logic [NUM_LANE*ACC_WIDTH-1:0] o_result,
    output logic                          o_result_valid
);

    localparam int W      = IN_DATA_WIDTH;
    localparam int LANE_W = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_RUN, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t              state;
    logic [CNT_BIT-1:0]  num_cnt_r;
    logic [CNT_BIT-1:0]  rd_cnt;
    logic [AWIDTH-1:0]   out_base_r;
    logic [LANE_W-1:0]   lane_cnt;
    logic                bias_valid;
    logic                data_valid;
    logic [ACC_WIDTH-1:0] res [NUM_LANE];

    // Every strobe is a register updated on the transition into its state, so the
    // outputs follow the state exactly and are all zero while reset is held.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            num_cnt_r      <= '0;
            rd_cnt         <= '0;
            out_base_r     <= '0;
            lane_cnt       <= '0;
            bias_valid     <= 1'b0;
            data_valid     <= 1'b0;
            o_idle         <= 1'b0;
            o_read         <= 1'b0;
            o_write        <= 1'b0;
            o_done         <= 1'b0;
            o_result_valid <= 1'b0;
            addr_b0        <= '0;
            addr_b1        <= '0;
            addr_b2        <= '0;
            addr_b3        <= '0;
            ce_b0          <= 1'b0;
            ce_b1          <= 1'b0;
            ce_b2          <= 1'b0;
            ce_b3          <= 1'b0;
            we_b3          <= 1'b0;
        end else begin
            bias_valid     <= (state == S_BIAS);
            data_valid     <= o_read;
            o_done         <= 1'b0;
            o_result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_idle <= ~i_run;
                    if (i_run) begin
                        num_cnt_r  <= i_num_cnt;
                        out_base_r <= i_out_base;
                        addr_b2    <= i_bias_addr;
                        ce_b2      <= 1'b1;
                        state      <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    ce_b2 <= 1'b0;
                    if (num_cnt_r != '0) begin
                        rd_cnt  <= '0;
                        addr_b0 <= '0;
                        addr_b1 <= '0;
                        ce_b0   <= 1'b1;
                        ce_b1   <= 1'b1;
                        o_read  <= 1'b1;
                        state   <= S_RUN;
                    end else begin
                        state <= S_DRAIN;
                    end
                end
                S_RUN: begin
                    if (rd_cnt == num_cnt_r - CNT_BIT'(1)) begin
                        ce_b0  <= 1'b0;
                        ce_b1  <= 1'b0;
                        o_read <= 1'b0;
                        state  <= S_DRAIN;
                    end else begin
                        rd_cnt  <= rd_cnt + CNT_BIT'(1);
                        addr_b0 <= AWIDTH'(rd_cnt + CNT_BIT'(1));
                        addr_b1 <= AWIDTH'(rd_cnt + CNT_BIT'(1));
                    end
                end
                S_DRAIN: begin
                    lane_cnt <= '0;
                    addr_b3  <= out_base_r;
                    ce_b3    <= 1'b1;
                    we_b3    <= 1'b1;
                    o_write  <= 1'b1;
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    if (lane_cnt == LANE_W'(NUM_LANE - 1)) begin
                        ce_b3          <= 1'b0;
                        we_b3          <= 1'b0;
                        o_write        <= 1'b0;
                        o_done         <= 1'b1;
                        o_result_valid <= 1'b1;
                        state          <= S_DONE;
                    end else begin
                        lane_cnt <= lane_cnt + LANE_W'(1);
                        addr_b3  <= addr_b3 + AWIDTH'(1);
                    end
                end
                S_DONE: begin
                    o_idle <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
        logic signed [W-1:0]         node;
        logic signed [W-1:0]         wgt;
        logic signed [W-1:0]         bias;
        logic signed [2*W-1:0]       prod;
        logic signed [ACC_WIDTH-1:0] acc;

        assign node = q_b0[k*W +: W];
        assign wgt  = q_b1[k*W +: W];
        assign bias = q_b2[k*W +: W];
        assign prod = node * wgt;

        // Bias load and data accumulation never coincide; the bias load restarts each run.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc <= '0;
            end else if (bias_valid) begin
                acc <= {{(ACC_WIDTH-W){bias[W-1]}}, bias};
            end else if (data_valid) begin
                acc <= acc + {{(ACC_WIDTH-2*W){prod[2*W-1]}}, prod};
            end
        end

`ifdef FC_MOVER_RELU_EN
        assign res[k] = acc[ACC_WIDTH-1] ? '0 : acc;
`else
        assign res[k] = acc;
`endif
        assign o_result[k*ACC_WIDTH +: ACC_WIDTH] = res[k];
    end

    // NOTE: a gated mux with an explicit else-value is pure combinational; no latch can form.
    assign d_b3 = we_b3 ? res[lane_cnt] : '0;

endmodule
